// File: rtl/bus_ep_pkg.sv
// Shared constants and helpers for the bus endpoint FIFO slice.
// Optional address filter: define BUS_EP_ADDR_FILTER_EN.
package bus_ep_pkg;

  localparam int BUS_ID_W = 8;
  localparam logic [BUS_ID_W-1:0] BUS_BROADCAST = 8'hFF;
  localparam int CNT_W = 8;
  localparam int PKT_MAX_W = 256;

  // Destination ID sits in the top BUS_ID_W bits of an sz-bit packet.
  function automatic logic [BUS_ID_W-1:0] dest_of(
    input logic [PKT_MAX_W-1:0] pkt,
    input int sz
  );
    return BUS_ID_W'(pkt >> (sz - BUS_ID_W));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bus_ep_fifo.sv
// Synchronous first-word fall-through FIFO with extra-bit pointers.
// Head reads as zero while the FIFO is empty.
module bus_ep_fifo
  import bus_ep_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr;
  logic         rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr = wr_en & ~full;
  assign rd = rd_en & ~empty;

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bus_endpoint_fifo.sv
// Bus-port endpoint: host TX FIFO drained by the bus, filtered RX FIFO.
// Define BUS_EP_ADDR_FILTER_EN to reject packets not for this ID.
module bus_endpoint_fifo
  import bus_ep_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int fifo_depth = 16,
  parameter logic [7:0] id = 8'd0,
  parameter logic [7:0] broadcast = BUS_BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [pckg_sz-1:0] rx_data,
  output logic [7:0]         rx_drop_cnt,
  output logic [7:0]         misroute_cnt,
  output logic               pop_err
);

  logic tx_full;
  logic tx_empty;
  logic rx_full;
  logic rx_empty;
  logic addr_ok;
  logic rx_wr;
  logic rx_drop;
  logic [PKT_MAX_W-1:0] push_ext;
  logic [BUS_ID_W-1:0]  dest;
  logic [CNT_W-1:0]     drop_q;
  logic                 pop_err_q;

  assign tx_ready = ~tx_full;
  assign pndng    = ~tx_empty;
  assign rx_valid = ~rx_empty;

  bus_ep_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .head    (D_pop)
  );

  assign push_ext = PKT_MAX_W'(D_push);
  assign dest     = dest_of(push_ext, pckg_sz);

`ifdef BUS_EP_ADDR_FILTER_EN
  logic [CNT_W-1:0] mis_q;

  assign addr_ok = (dest == id) || (dest == broadcast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= '0;
    else if (push & ~addr_ok) mis_q <= sat_inc(mis_q);
  end

  assign misroute_cnt = mis_q;
`else
  logic unused_dest;

  assign unused_dest  = ^dest;
  assign addr_ok      = 1'b1;
  assign misroute_cnt = '0;
`endif

  // Fullness is the registered state, so a same-cycle read never rescues a push.
  assign rx_wr   = push & addr_ok & ~rx_full;
  assign rx_drop = push & addr_ok & rx_full;

  bus_ep_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (D_push),
    .rd_en   (rx_ready),
    .full    (rx_full),
    .empty   (rx_empty),
    .head    (rx_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q    <= '0;
      pop_err_q <= 1'b0;
    end else begin
      if (rx_drop) drop_q <= sat_inc(drop_q);
      if (pop & tx_empty) pop_err_q <= 1'b1;
    end
  end

  assign rx_drop_cnt = drop_q;
  assign pop_err     = pop_err_q;

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Directed bench for bus_endpoint_fifo (id=2, depth 16, 16-bit packets).
// Expectations follow BUS_EP_ADDR_FILTER_EN when it is defined.
module tb_bus_endpoint_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        pndng;
  logic        pop;
  logic [15:0] D_pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic [7:0]  rx_drop_cnt;
  logic [7:0]  misroute_cnt;
  logic        pop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_endpoint_fifo #(
    .pckg_sz(16),
    .fifo_depth(16),
    .id(8'd2),
    .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .pndng(pndng),
    .pop(pop),
    .D_pop(D_pop),
    .push(push),
    .D_push(D_push),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_drop_cnt(rx_drop_cnt),
    .misroute_cnt(misroute_cnt),
    .pop_err(pop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk1({tag, "_tx_ready"}, tx_ready, 1'b1);
    chk1({tag, "_pndng"}, pndng, 1'b0);
    chk1({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk16({tag, "_D_pop"}, D_pop, 16'h0000);
    chk16({tag, "_rx_data"}, rx_data, 16'h0000);
    chk8({tag, "_drop"}, rx_drop_cnt, 8'd0);
    chk8({tag, "_mis"}, misroute_cnt, 8'd0);
    chk1({tag, "_pop_err"}, pop_err, 1'b0);
  endtask

  initial begin
    logic [15:0] exp_q [$];
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    pop = 1'b0;
    push = 1'b0;
    D_push = '0;
    rx_ready = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // three host packets, then three pops
    tx_valid = 1'b1;
    tx_data = 16'h01AA;
    tick();
    chk1("tx1_pndng", pndng, 1'b1);
    chk16("tx1_head", D_pop, 16'h01AA);
    tx_data = 16'h02BB;
    tick();
    tx_data = 16'h03CC;
    tick();
    tx_valid = 1'b0;
    chk16("tx3_head", D_pop, 16'h01AA);
    pop = 1'b1;
    tick();
    chk16("pop1", D_pop, 16'h02BB);
    tick();
    chk16("pop2", D_pop, 16'h03CC);
    chk1("pop2_pndng", pndng, 1'b1);
    tick();
    pop = 1'b0;
    chk1("pop3_pndng", pndng, 1'b0);
    chk16("pop3_head", D_pop, 16'h0000);

    // fill TX, overflow, then simultaneous pop and write
    tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = 16'h1000 + 16'(i);
      tick();
    end
    chk1("full_ready", tx_ready, 1'b0);
    tx_data = 16'hDEAD;
    tick();
    tx_valid = 1'b0;
    chk1("ovf_ready", tx_ready, 1'b0);
    chk16("ovf_head", D_pop, 16'h1000);
    pop = 1'b1;
    tick();
    chk1("pop_ready", tx_ready, 1'b1);
    chk16("pop_head", D_pop, 16'h1001);
    tx_valid = 1'b1;
    tx_data = 16'h2000;
    tick();
    tx_valid = 1'b0;
    pop = 1'b0;
    chk1("rw_ready", tx_ready, 1'b1);
    chk16("rw_head", D_pop, 16'h1002);
    for (int i = 2; i < 16; i++) exp_q.push_back(16'h1000 + 16'(i));
    exp_q.push_back(16'h2000);
    for (int i = 0; i < 15; i++) begin
      chk16("tx_drain", D_pop, exp_q[i]);
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    chk1("tx_drain_pndng", pndng, 1'b0);
    chk1("tx_no_pop_err", pop_err, 1'b0);

    // address filter
    push = 1'b1;
    D_push = 16'h0211;
    tick();
    D_push = 16'hFF22;
    tick();
    D_push = 16'h0533;
    tick();
    push = 1'b0;
`ifdef BUS_EP_ADDR_FILTER_EN
    chk8("filt_mis", misroute_cnt, 8'd1);
    chk16("filt_rx0", rx_data, 16'h0211);
    rx_ready = 1'b1;
    tick();
    chk16("filt_rx1", rx_data, 16'hFF22);
    tick();
`else
    chk8("filt_mis", misroute_cnt, 8'd0);
    chk16("filt_rx0", rx_data, 16'h0211);
    rx_ready = 1'b1;
    tick();
    chk16("filt_rx1", rx_data, 16'hFF22);
    tick();
    chk16("filt_rx2", rx_data, 16'h0533);
    tick();
`endif
    rx_ready = 1'b0;
    chk1("filt_empty", rx_valid, 1'b0);
    chk8("filt_drop", rx_drop_cnt, 8'd0);

    // fill RX, drop with same-cycle read, then saturate
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      D_push = 16'h0200 + 16'(i);
      tick();
    end
    D_push = 16'h02EE;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk8("drop_rd_cnt", rx_drop_cnt, 8'd1);
    chk16("drop_rd_head", rx_data, 16'h0201);
    D_push = 16'h0210;
    tick();
`ifdef BUS_EP_ADDR_FILTER_EN
    D_push = 16'h0733;
    tick();
    chk8("mis_full_mis", misroute_cnt, 8'd2);
    chk8("mis_full_drop", rx_drop_cnt, 8'd1);
`endif
    D_push = 16'h02EE;
    for (int i = 0; i < 300; i++) tick();
    push = 1'b0;
    chk8("drop_sat", rx_drop_cnt, 8'd255);
    for (int i = 0; i < 16; i++) begin
      chk16("rx_drain", rx_data, 16'h0201 + 16'(i));
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk1("rx_drain_empty", rx_valid, 1'b0);

    // pop error is sticky
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk1("pop_err_set", pop_err, 1'b1);
    tick();
    chk1("pop_err_hold", pop_err, 1'b1);

    // asynchronous reset with five entries in each FIFO
    tx_valid = 1'b1;
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 16'h3000 + 16'(i);
      D_push = 16'h0240 + 16'(i);
      tick();
    end
    tx_valid = 1'b0;
    push = 1'b0;
    chk1("pre_rst_pndng", pndng, 1'b1);
    chk1("pre_rst_rx_valid", rx_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    tick();
    reset = 1'b0;
    tick();
    chk_reset_vals("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_endpoint_fifo.md
# bus_endpoint_fifo

Device-side endpoint of the bus generator/arbiter protocol: one instance per bus port serves the bus's `pndng`/`pop`/`D_pop` and `push`/`D_push` signals. Outbound packets from a local host enter a TX FIFO that the bus drains. Inbound packets pushed by the bus enter an RX FIFO after destination filtering, and the host drains them. It replaces the behavioural FIFO model in the driver, so the bus can be closed around synthesizable endpoints.

## Interface
- `pckg_sz`, 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
- `fifo_depth`, 16: entries per FIFO; power of two, ≥2.
- `id`, 0: this endpoint's 8-bit bus ID.
- `broadcast`, 8'hFF: destination ID accepted by every endpoint.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `tx_valid` in 1: host offers `tx_data`.
- `tx_ready` out 1: TX FIFO not full.
- `tx_data` in pckg_sz: outbound packet.
- `pndng` out 1: TX FIFO not empty (bus-facing).
- `pop` in 1: bus consumes TX head this cycle.
- `D_pop` out pckg_sz: TX FIFO head (first-word fall-through).
- `push` in 1: bus delivers `D_push` this cycle.
- `D_push` in pckg_sz: inbound packet.
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: host consumes RX head.
- `rx_data` out pckg_sz: RX FIFO head.
- `rx_drop_cnt` out 8: saturating count of inbound packets dropped because the RX FIFO was full.
- `misroute_cnt` out 8: saturating count of inbound packets rejected by the address filter.
- `pop_err` out 1: sticky; set by `pop` while `pndng`=0.

## Operation
- TX write occurs when `tx_valid & tx_ready`. TX read occurs when `pop & pndng`. Both may occur in the same cycle; occupancy is then unchanged.
- `pop` with `pndng`=0: no state change except `pop_err`, which stays set until reset.
- Inbound `push`: the destination is `D_push[pckg_sz-1 -: 8]`. The packet is accepted if the destination equals `id` or `broadcast` (see Configuration) and the RX FIFO is not full.
- `push` while RX is full drops the packet and increments `rx_drop_cnt`. This holds even if `rx_ready` is asserted in the same cycle: fullness is sampled before the read.
- RX read occurs when `rx_valid & rx_ready`. A simultaneous accepted push and read leaves occupancy unchanged.
- Pointers are $clog2(fifo_depth)+1 bits wide; the extra bit distinguishes full from empty. Wrap-around is natural modulo 2·depth.
- Counters saturate at 255 and never wrap.
- Packets are stored unmodified; the destination field is not stripped.
- Reset values: `tx_ready`=1, `pndng`=0, `rx_valid`=0, `D_pop`=0, `rx_data`=0, both counters=0, `pop_err`=0. Reset asserted mid-transfer discards all FIFO contents immediately.

## Timing
- TX write at edge N: `pndng`=1 and `D_pop` valid after edge N (visible in cycle N+1). Latency is 1 cycle.
- `pop` at edge N: `D_pop` shows the next entry after edge N. `pndng` falls after edge N if that was the last entry.
- `push` at edge N: `rx_valid`/`rx_data` are valid after edge N.
- `tx_ready`, `pndng` and `rx_valid` are decoded from registered pointers only, with no combinational input-to-output paths.
- `D_pop` and `rx_data` are read from the storage array at the read pointer. Both are 0 when the FIFO is empty.
- Counters and `pop_err` update on the edge that samples the triggering event.

## Configuration
- `BUS_EP_ADDR_FILTER_EN` defined: inbound packets whose destination is neither `id` nor `broadcast` are discarded and `misroute_cnt` increments. A misrouted packet arriving while RX is full counts as misrouted only.
- Not defined: every inbound packet is a candidate for the RX FIFO, and `misroute_cnt` is tied to 0.

## Structure
- Package `bus_ep_pkg` holds:
  - `BUS_ID_W`=8
  - `BUS_BROADCAST`=8'hFF
  - a function `dest_of(pkt)` returning the top 8 bits
  - `CNT_W`=8 with a saturating-increment function
- Sub-module `bus_ep_fifo` is a parameterized (width, depth) synchronous FWFT FIFO with `wr_en`, `rd_en`, `full`, `empty` and `head`. It is instantiated twice, once for TX and once for RX.
- The top level holds the address filter, counters and `pop_err`.

## Test plan
- Reset, then write 3 host packets 16'h01AA, 16'h02BB, 16'h03CC → `pndng`=1 one cycle after the first write; three consecutive `pop`s yield `D_pop` = 01AA, 02BB, 03CC; `pndng`=0 after the third pop.
- Fill TX with 16 writes → `tx_ready`=0. A 17th write is ignored. `pop` and host write in the same cycle once not full → count stays 15.
- With `id`=2, push 16'h02_11, 16'hFF_22 and 16'h05_33 → RX holds 0211 and FF22. With the filter macro, `misroute_cnt`=1; without it, RX holds all 3 and the count is 0.
- Fill RX (16 entries), then push 300 more packets addressed to `id` → `rx_drop_cnt`=255 (saturated). RX contents are unchanged.
- `pop` while empty → `pop_err`=1 and it stays 1. Assert `reset` asynchronously mid-cycle with 5 entries in each FIFO → all outputs return to reset values before the next edge.
